simple_bus_initiator: RTL and testbench
=======================================

// Module: simple_bus_initiator
// PURPOSE
//  CPU-side master for the simple_bus protocol: the requesting end opposite the memory responder.
//  Accepts one command at a time on a valid/ready port and runs req -> gnt -> start -> rdy on the bus.
//  Returns read data, or a completion for writes, on a valid/ready response port.
//  Bus outputs are wired to the req/addr/data/mode/start fields of a simple_bus instance at top level.
// PARAMETERS
//  ADDR_W          8   bus address width (matches simple_bus addr)
//  DATA_W          8   bus data width (matches simple_bus data)
//  TIMEOUT_CYCLES  16  max cycles waiting for gnt or for rdy (used only with timeout macro)
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       initiator can accept command (IDLE only)
//  cmd_mode     in   2       mode_t: READ=2'b00, WRITE=2'b01, 2'b10/2'b11 passed through to bus
//  cmd_addr     in   ADDR_W  target address
//  cmd_wdata    in   DATA_W  write data
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       response consumed
//  rsp_rdata    out  DATA_W  read data (0 for writes and errors)
//  rsp_err      out  1       transaction timed out (tied 0 without macro)
//  bus_req      out  1       simple_bus req
//  bus_gnt      in   1       simple_bus gnt
//  bus_start    out  1       simple_bus start, 1-cycle pulse
//  bus_mode     out  2       simple_bus mode
//  bus_addr     out  ADDR_W  simple_bus addr
//  bus_wdata    out  DATA_W  data driven to bus
//  bus_data_oe  out  1       bus_wdata valid (WRITE mode, START through WAIT_RDY)
//  bus_rdata    in   DATA_W  data returned by responder
//  bus_rdy      in   1       simple_bus rdy, transfer complete
// BEHAVIOUR
//  All outputs are registered. On reset all outputs are 0, except cmd_ready, which is 1.
//  The state goes to IDLE one edge after rst is sampled high, including mid-transaction.
//  An in-flight transaction is dropped silently on reset; no response is produced.
//  FSM states:
//   IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch mode/addr/wdata, set bus_req=1, go to REQ.
//   REQ: bus_req=1. bus_rdy is ignored. On bus_gnt, go to START.
//   START: bus_start=1 for exactly one cycle, with addr/mode/wdata stable. bus_req is held. bus_rdy is ignored. Go to WAIT_RDY.
//   WAIT_RDY: bus_req=1 and bus_gnt is ignored. On bus_rdy, capture bus_rdata (READ) or 0 (other modes), drop bus_req and bus_data_oe, go to RESP.
//   RESP: rsp_valid=1 and held with stable data until rsp_ready, then go to IDLE. No new command is accepted in the same cycle.
//  Latency: command handshake at edge N gives bus_req=1 after N.
//  Gnt sampled at edge G gives bus_start during G..G+1.
//  Rdy sampled at edge R>G+1 gives rsp_valid after R.
//  Best-case round trip, with the responder granting the cycle after req, is 5 cycles.
//  bus_addr/bus_mode hold their last value outside a transaction. Throughput: 1 outstanding transaction.
// CONFIGURATION
//  SIMPLE_BUS_INIT_TIMEOUT_EN defined:
//   A counter clears on entry to REQ and to WAIT_RDY, and increments each cycle in those states.
//   When the count reaches TIMEOUT_CYCLES without gnt/rdy, drop bus_req/bus_data_oe and go to RESP with rsp_err=1, rsp_rdata=0.
//   Gnt or rdy arriving in the same cycle as the terminal count wins (no error).
//  SIMPLE_BUS_INIT_TIMEOUT_EN undefined: no counter; waits indefinitely; rsp_err is constant 0.
// STRUCTURE
//  simple_bus_pkg: mode_t enum (MODE_READ, MODE_WRITE), init_state_t enum (IDLE, REQ, START, WAIT_RDY, RESP), default ADDR_W/DATA_W localparams.
//  Sub-module simple_bus_init_timer (clear, enable, TIMEOUT_CYCLES, expired):
//   instantiated only under SIMPLE_BUS_INIT_TIMEOUT_EN.
//   Counter width is $clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 Read:
//   - Stimulus: cmd READ addr=8'h3C. Responder grants the next cycle and asserts rdy 2 cycles after start, with bus_rdata=8'hA5.
//   - Response: one start pulse with addr=8'h3C, mode=2'b00. Then rsp_valid with rsp_rdata=8'hA5, rsp_err=0.
//  2 Write:
//   - Stimulus: cmd WRITE addr=8'h10, wdata=8'h5A.
//   - Response: bus_data_oe=1 with bus_wdata=8'h5A from start through rdy. rsp_rdata=0.
//  3 Delayed gnt plus stray rdy:
//   - Stimulus: gnt is held low for 6 cycles; rdy is pulsed during REQ and during START.
//   - Response: both rdy pulses are ignored; exactly one start pulse follows the gnt; the response follows the first WAIT_RDY rdy.
//  4 Backpressure:
//   - Stimulus: rsp_ready=0 for 4 cycles, with cmd_valid held high.
//   - Response: rsp_valid and rsp_rdata stay stable; cmd_ready=0 until the cycle after rsp_ready.
//  5 Reset mid-op:
//   - Stimulus: rst asserted 1 cycle while in WAIT_RDY.
//   - Response: next cycle bus_req=0, bus_start=0, rsp_valid=0, cmd_ready=1. A late rdy is ignored.
//  6 Timeout (macro on, TIMEOUT_CYCLES=16):
//   - Stimulus: gnt is never asserted.
//   - Response: bus_req drops after 16 REQ cycles; rsp_valid=1 with rsp_err=1, rsp_rdata=0.
//   - Macro off: bus_req stays high for 100+ cycles and rsp_err never goes to 1.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// Shared types and default widths for the simple_bus initiator slice.
package simple_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    MODE_READ  = 2'b00,
    MODE_WRITE = 2'b01
  } mode_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    START    = 3'd2,
    WAIT_RDY = 3'd3,
    RESP     = 3'd4
  } init_state_t;

endpackage

// File: rtl/simple_bus_init_timer.sv
// Wait-cycle counter for the initiator; flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module simple_bus_init_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  assign count_nxt_s = count_r + CNT_W'(1);
  // The cycle whose increment would reach the limit is the terminal one.
  assign expired     = enable && (count_nxt_s == CNT_W'(TIMEOUT_CYCLES));

  // Count enabled cycles, saturating at the limit; clear restarts a wait window.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != CNT_W'(TIMEOUT_CYCLES))) begin
      count_r <= count_nxt_s;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/simple_bus_initiator.sv
// CPU-side simple_bus master: one command at a time, req -> gnt -> start -> rdy, then response.
// Optional wait timeout enabled by defining SIMPLE_BUS_INIT_TIMEOUT_EN.
module simple_bus_initiator #(
  parameter int ADDR_W         = simple_bus_pkg::ADDR_W,
  parameter int DATA_W         = simple_bus_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_start,
  output logic [1:0]        bus_mode,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rdy
);

  import simple_bus_pkg::*;

  localparam logic [2:0] S_IDLE     = 3'(IDLE);
  localparam logic [2:0] S_REQ      = 3'(REQ);
  localparam logic [2:0] S_START    = 3'(START);
  localparam logic [2:0] S_WAIT_RDY = 3'(WAIT_RDY);
  localparam logic [2:0] S_RESP     = 3'(RESP);

  logic [2:0]        state_r;
  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              bus_req_r;
  logic              bus_start_r;
  logic [1:0]        bus_mode_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic              bus_data_oe_r;
  logic              cmd_fire_s;
  logic              expired_s;

  assign cmd_fire_s = cmd_valid && cmd_ready_r;

`ifdef SIMPLE_BUS_INIT_TIMEOUT_EN
  logic timer_clear_s;
  logic timer_enable_s;

  // Restart the window on entry to REQ (command accepted) and to WAIT_RDY (leaving START).
  assign timer_clear_s  = ((state_r == S_IDLE) && cmd_fire_s) || (state_r == S_START);
  assign timer_enable_s = (state_r == S_REQ) || (state_r == S_WAIT_RDY);

  simple_bus_init_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .enable  (timer_enable_s),
    .expired (expired_s)
  );
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign expired_s        = 1'b0;
`endif

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      cmd_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      bus_req_r     <= 1'b0;
      bus_start_r   <= 1'b0;
      bus_mode_r    <= 2'b00;
      bus_addr_r    <= {ADDR_W{1'b0}};
      bus_wdata_r   <= {DATA_W{1'b0}};
      bus_data_oe_r <= 1'b0;
    end else begin
      bus_start_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cmd_fire_s) begin
            bus_mode_r  <= cmd_mode;
            bus_addr_r  <= cmd_addr;
            bus_wdata_r <= cmd_wdata;
            bus_req_r   <= 1'b1;
            cmd_ready_r <= 1'b0;
            state_r     <= S_REQ;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        S_REQ: begin
          // Grant beats a simultaneous terminal count.
          if (bus_gnt) begin
            bus_start_r   <= 1'b1;
            bus_data_oe_r <= (bus_mode_r == MODE_WRITE);
            state_r       <= S_START;
          end else if (expired_s) begin
            bus_req_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= {DATA_W{1'b0}};
            state_r     <= S_RESP;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_START: begin
          state_r <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (bus_rdy) begin
            bus_req_r     <= 1'b0;
            bus_data_oe_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= (bus_mode_r == MODE_READ) ? bus_rdata : {DATA_W{1'b0}};
            state_r       <= S_RESP;
          end else if (expired_s) begin
            bus_req_r     <= 1'b0;
            bus_data_oe_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= 1'b1;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            state_r       <= S_RESP;
          end else begin
            state_r <= S_WAIT_RDY;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r       <= S_IDLE;
          cmd_ready_r   <= 1'b1;
          rsp_valid_r   <= 1'b0;
          rsp_err_r     <= 1'b0;
          bus_req_r     <= 1'b0;
          bus_data_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign bus_req     = bus_req_r;
  assign bus_start   = bus_start_r;
  assign bus_mode    = bus_mode_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign bus_data_oe = bus_data_oe_r;

endmodule

// File: tb/tb_simple_bus_initiator.sv
// Directed self-checking bench for simple_bus_initiator with a hand-driven responder.
module tb_simple_bus_initiator;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       bus_req;
  logic       bus_gnt;
  logic       bus_start;
  logic [1:0] bus_mode;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_data_oe;
  logic [7:0] bus_rdata;
  logic       bus_rdy;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int start_cnt = 0;
  int start_ref = 0;
  logic req_dropped;
  logic err_seen;

  simple_bus_initiator #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .bus_req     (bus_req),
    .bus_gnt     (bus_gnt),
    .bus_start   (bus_start),
    .bus_mode    (bus_mode),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_data_oe (bus_data_oe),
    .bus_rdata   (bus_rdata),
    .bus_rdy     (bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; count start pulses seen after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_start === 1'b1) start_cnt++;
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    rsp_ready = 1'b0; bus_gnt = 1'b0; bus_rdata = 8'h00; bus_rdy = 1'b0;
    tick(); tick();
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_bus_req", bus_req, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_bus_addr", bus_addr, 0);
    check_val("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();

    // 1: read, grant next cycle, rdy two cycles after start
    start_ref = start_cnt;
    send_cmd(2'b00, 8'h3C, 8'h00);
    check_val("rd_req", bus_req, 1);
    check_val("rd_cmd_ready", cmd_ready, 0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check_val("rd_start", bus_start, 1);
    check_val("rd_addr", bus_addr, 8'h3C);
    check_val("rd_mode", bus_mode, 2'b00);
    check_val("rd_oe", bus_data_oe, 0);
    tick();
    check_val("rd_start_end", bus_start, 0);
    bus_rdy = 1'b1; bus_rdata = 8'hA5;
    tick();
    bus_rdy = 1'b0;
    check_val("rd_rsp_valid", rsp_valid, 1);
    check_val("rd_rdata", rsp_rdata, 8'hA5);
    check_val("rd_err", rsp_err, 0);
    check_val("rd_req_drop", bus_req, 0);
    check_val("rd_starts", start_cnt - start_ref, 1);
    drain_rsp();
    check_val("rd_done_valid", rsp_valid, 0);
    check_val("rd_done_ready", cmd_ready, 1);

    // 2: write
    send_cmd(2'b01, 8'h10, 8'h5A);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check_val("wr_start", bus_start, 1);
    check_val("wr_oe_start", bus_data_oe, 1);
    check_val("wr_wdata", bus_wdata, 8'h5A);
    check_val("wr_mode", bus_mode, 2'b01);
    tick();
    check_val("wr_oe_wait", bus_data_oe, 1);
    bus_rdy = 1'b1; bus_rdata = 8'hFF;
    tick();
    bus_rdy = 1'b0;
    check_val("wr_rsp_valid", rsp_valid, 1);
    check_val("wr_rdata_zero", rsp_rdata, 8'h00);
    check_val("wr_oe_drop", bus_data_oe, 0);
    drain_rsp();

    // 3: gnt low 6 cycles, stray rdy in REQ and in START
    start_ref = start_cnt;
    send_cmd(2'b00, 8'h77, 8'h00);
    for (int i = 0; i < 6; i++) begin
      bus_rdy = (i == 2);
      tick();
    end
    bus_rdy = 1'b0;
    check_val("dg_req_hold", bus_req, 1);
    check_val("dg_no_rsp", rsp_valid, 0);
    check_val("dg_no_start", start_cnt - start_ref, 0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rdy = 1'b1; bus_rdata = 8'h11;
    tick();
    bus_rdy = 1'b0;
    check_val("dg_start_rdy_ign", rsp_valid, 0);
    tick();
    check_val("dg_wait", rsp_valid, 0);
    bus_rdy = 1'b1; bus_rdata = 8'hC3;
    tick();
    bus_rdy = 1'b0;
    check_val("dg_rsp_valid", rsp_valid, 1);
    check_val("dg_rdata", rsp_rdata, 8'hC3);
    check_val("dg_one_start", start_cnt - start_ref, 1);
    drain_rsp();

    // 4: backpressure with a pending command offered
    send_cmd(2'b00, 8'h22, 8'h00);
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    tick();
    bus_rdy = 1'b1; bus_rdata = 8'h9E; tick(); bus_rdy = 1'b0;
    cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_addr = 8'h44;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("bp_valid", rsp_valid, 1);
      check_val("bp_rdata", rsp_rdata, 8'h9E);
      check_val("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("bp_release_valid", rsp_valid, 0);
    check_val("bp_release_ready", cmd_ready, 1);
    check_val("bp_no_accept", bus_req, 0);
    tick();
    cmd_valid = 1'b0;
    check_val("bp_next_accept", bus_req, 1);
    check_val("bp_next_addr", bus_addr, 8'h44);

    // 5: reset while in WAIT_RDY, then a late rdy
    bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_req", bus_req, 0);
    check_val("mr_start", bus_start, 0);
    check_val("mr_valid", rsp_valid, 0);
    check_val("mr_ready", cmd_ready, 1);
    bus_rdy = 1'b1; bus_rdata = 8'h55;
    tick();
    bus_rdy = 1'b0;
    check_val("mr_late_rdy", rsp_valid, 0);
    check_val("mr_late_req", bus_req, 0);

    // 6: gnt never arrives
    send_cmd(2'b00, 8'h66, 8'h00);
`ifdef SIMPLE_BUS_INIT_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check_val("to_req_15", bus_req, 1);
    tick();
    check_val("to_req_drop", bus_req, 0);
    check_val("to_valid", rsp_valid, 1);
    check_val("to_err", rsp_err, 1);
    check_val("to_rdata", rsp_rdata, 8'h00);
    drain_rsp();
`else
    req_dropped = 1'b0;
    err_seen    = 1'b0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (bus_req !== 1'b1) req_dropped = 1'b1;
      if (rsp_err !== 1'b0) err_seen = 1'b1;
    end
    check_val("nto_req_held", req_dropped, 0);
    check_val("nto_no_err", err_seen, 0);
    check_val("nto_no_rsp", rsp_valid, 0);
    rst = 1'b1; tick(); rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
